quiz_round_controller: RTL and testbench
========================================

# quiz_round_controller

Round sequencer for the four-player quiz buzzer system. It arms the contestant keys on a host command and grants the first valid press. It then starts and reloads the 30 s countdown timer, collects the judge's verdict or the timer expiry, and keeps per-player scores. It sits between the debounced front-panel inputs and the timer/display blocks.

## Interface
- SCORE_MAX, 9: saturating upper limit of each score (BCD digit display).
- CLK  in  1  system clock.
- RSTn  in  1  asynchronous active-low reset.
- Host_Start  in  1  one-cycle pulse; opens a round.
- Host_Abort  in  1  one-cycle pulse; cancels the round from any state.
- Player_Key  in  4  contestant keys, active-high level, already synchronized/debounced.
- Judge_Correct, Judge_Wrong  in  1 each  one-cycle verdict pulses.
- TimerH, TimerL  in  4 each  BCD countdown digits from the timer.
- Timer_Start  out  1  enables the timer; low clears its prescaler.
- Timer_RSTn  out  1  active-low reload pulse to the timer (reloads 30).
- Winner  out  2  index of the granted player.
- Winner_Valid  out  1  high while a grant is held.
- Player_LED  out  4  one-hot of the granted player.
- Foul  out  4  false-start flags.
- Score  out  16  four 4-bit scores; player i at [4i+3:4i].

## Operation
- States: IDLE, ARMED, ANSWER.
- Key edges: Player_Key registered each cycle. A press is a rising edge (key high, previous sample low). Keys held across a state change never count.
- IDLE:
  - Press by player i sets Foul[i].
  - Host_Start -> ARMED.
  - Judge pulses ignored.
- ARMED:
  - Presses from fouled players are ignored.
  - Among non-fouled players pressing in the same cycle, the lowest index wins.
  - Grant -> ANSWER: Winner, Player_LED and Winner_Valid are loaded.
  - If every player is fouled, stay in ARMED until Host_Abort.
- ANSWER: grant held until exit.
  - Judge_Correct alone: winner's score +1, saturating at SCORE_MAX.
  - Judge_Wrong alone: winner's score -1, saturating at 0.
  - Both pulses in the same cycle: ignored.
  - Timeout (TimerH==0 and TimerL==0): treated as wrong.
  - Any of these exits -> IDLE: grant cleared, Foul cleared, Timer_Start low.
- Host_Abort, any state:
  - Next state IDLE; grant and Foul cleared.
  - Scores unchanged, Timer_Start low.
  - Abort has priority over every other event in that cycle.
- Host_Start outside IDLE: ignored.
- Priority within ANSWER: Abort > valid judge pulse > timeout.
- Scores change only on ANSWER exits; no other path modifies them.

## Timing
- Reset values:
  - State IDLE.
  - Timer_Start 0, Timer_RSTn 1.
  - Winner 0, Winner_Valid 0, Player_LED 0.
  - Foul 0, Score all 0, key history 0.
- Grant latency:
  - Key rising edge sampled at edge n.
  - Winner, Winner_Valid and Player_LED valid after edge n+1.
  - Timer_RSTn low during cycle n+1 only (one full cycle).
  - Timer_Start high from edge n+2 while in ANSWER.
- Timeout qualification: ignored until Timer_Start has been high for at least 2 cycles. This prevents stale 0/0 digits from the previous round ending the new one before the reload takes effect.
- Verdict/timeout at edge m:
  - Score update, state IDLE and grant clear all visible after edge m+1.
  - Timer_Start low after edge m+1.
- Foul set is visible one cycle after the edge is sampled.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset mid-ANSWER with scores nonzero -> all outputs return to reset values immediately, without waiting for a clock.
- Host_Start, then keys 4'b0110 rising in the same cycle -> Winner=1, Player_LED=4'b0010. Timer_RSTn low for 1 cycle, then Timer_Start=1.
- Player 2 presses in IDLE -> Foul=4'b0100. After Host_Start, player 2 presses then player 3 presses -> Winner=3. After the verdict, Foul=0.
- Grant player 0, Judge_Correct repeated 10 rounds -> Score[3:0] saturates at 9. Judge_Wrong with score 0 -> stays 0.
- Grant player 1, drive TimerH/TimerL=0/0 one cycle after grant -> ignored. Drive 0/0 after 2 cycles -> Score[7:4] decremented (saturating), state IDLE. Judge_Correct and timeout in the same cycle -> +1 applied.
- Host_Abort in ANSWER together with Judge_Correct -> IDLE, scores unchanged. Judge_Correct+Judge_Wrong together -> no change, stays in ANSWER.

Source files
------------

// File: rtl/quiz_round_controller.sv
// quiz_round_controller: round sequencer for the four-player buzzer system.
// Every input is registered once before the FSM acts on it. So a key edge,
// host command, judge pulse or timer-zero sampled at edge n takes effect at
// edge n+1. This also means no input reaches an output combinationally.
module quiz_round_controller #(
    parameter int SCORE_MAX = 9
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        Host_Start,
    input  logic        Host_Abort,
    input  logic [3:0]  Player_Key,
    input  logic        Judge_Correct,
    input  logic        Judge_Wrong,
    input  logic [3:0]  TimerH,
    input  logic [3:0]  TimerL,
    output logic        Timer_Start,
    output logic        Timer_RSTn,
    output logic [1:0]  Winner,
    output logic        Winner_Valid,
    output logic [3:0]  Player_LED,
    output logic [3:0]  Foul,
    output logic [15:0] Score
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ANSWER} state_t;

    state_t          r_state, w_next;
    logic            r_start, r_abort, r_jc, r_jw, r_tz;
    logic [3:0]      r_key, r_key_q;
    logic            r_tstart, r_ts_seen, r_trstn;
    logic [1:0]      r_winner;
    logic            r_wvalid;
    logic [3:0]      r_led, r_foul;
    logic [3:0][3:0] r_score;

    logic [3:0]      w_press, w_elig;
    logic [1:0]      w_gidx;
    logic            w_jvalid, w_up, w_verdict;
    logic            w_do_grant, w_do_score, w_clear;

    // Sample inputs; timer zero only counts once Timer_Start has been high 2 cycles
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_start   <= 1'b0;
            r_abort   <= 1'b0;
            r_jc      <= 1'b0;
            r_jw      <= 1'b0;
            r_key     <= 4'b0;
            r_key_q   <= 4'b0;
            r_tz      <= 1'b0;
            r_ts_seen <= 1'b0;
        end else begin
            r_start   <= Host_Start;
            r_abort   <= Host_Abort;
            r_jc      <= Judge_Correct;
            r_jw      <= Judge_Wrong;
            r_key     <= Player_Key;
            r_key_q   <= r_key;
            r_ts_seen <= r_tstart;
            r_tz      <= (TimerH == 4'd0) && (TimerL == 4'd0) && r_tstart && r_ts_seen;
        end
    end

    assign w_press   = r_key & ~r_key_q;
    assign w_elig    = w_press & ~r_foul;
    assign w_jvalid  = r_jc ^ r_jw;
    assign w_up      = w_jvalid & r_jc;
    assign w_verdict = w_jvalid | r_tz;

    // Lowest-index eligible presser wins a same-cycle tie
    always_comb begin
        w_gidx = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (w_elig[i]) w_gidx = 2'(i);
    end

    // State register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state and round events; abort overrides everything
    always_comb begin
        w_next     = r_state;
        w_do_grant = 1'b0;
        w_do_score = 1'b0;
        w_clear    = 1'b0;
        if (r_abort) begin
            w_next  = S_IDLE;
            w_clear = 1'b1;
        end else begin
            case (r_state)
                S_IDLE:   if (r_start) w_next = S_ARMED;
                S_ARMED:  if (|w_elig) begin
                              w_next     = S_ANSWER;
                              w_do_grant = 1'b1;
                          end
                S_ANSWER: if (w_verdict) begin
                              w_next     = S_IDLE;
                              w_clear    = 1'b1;
                              w_do_score = 1'b1;
                          end
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Timer control: reload pulse on the grant cycle, run while answering
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_tstart <= 1'b0;
            r_trstn  <= 1'b1;
        end else begin
            r_tstart <= (r_state == S_ANSWER) && (w_next == S_ANSWER);
            r_trstn  <= ~w_do_grant;
        end
    end

    // Grant and foul flags
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_winner <= 2'd0;
            r_wvalid <= 1'b0;
            r_led    <= 4'b0;
            r_foul   <= 4'b0;
        end else if (w_clear) begin
            r_winner <= 2'd0;
            r_wvalid <= 1'b0;
            r_led    <= 4'b0;
            r_foul   <= 4'b0;
        end else begin
            if (w_do_grant) begin
                r_winner <= w_gidx;
                r_wvalid <= 1'b1;
                r_led    <= 4'b0001 << w_gidx;
            end
            if (r_state == S_IDLE) r_foul <= r_foul | w_press;
        end
    end

    // Saturating score update, only on a verdict/timeout exit from ANSWER
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_score <= '0;
        end else if (w_do_score) begin
            if (w_up) begin
                if (r_score[r_winner] < 4'(SCORE_MAX))
                    r_score[r_winner] <= r_score[r_winner] + 4'd1;
            end else if (r_score[r_winner] != 4'd0) begin
                r_score[r_winner] <= r_score[r_winner] - 4'd1;
            end
        end
    end

    assign Timer_Start  = r_tstart;
    assign Timer_RSTn   = r_trstn;
    assign Winner       = r_winner;
    assign Winner_Valid = r_wvalid;
    assign Player_LED   = r_led;
    assign Foul         = r_foul;
    assign Score        = r_score;

endmodule

// File: tb/tb_quiz_round_controller.sv
// Directed bench for quiz_round_controller with hand-computed expectations.
module tb_quiz_round_controller;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        Host_Start = 1'b0, Host_Abort = 1'b0;
    logic [3:0]  Player_Key = 4'b0;
    logic        Judge_Correct = 1'b0, Judge_Wrong = 1'b0;
    logic [3:0]  TimerH = 4'd3, TimerL = 4'd0;
    logic        Timer_Start, Timer_RSTn, Winner_Valid;
    logic [1:0]  Winner;
    logic [3:0]  Player_LED, Foul;
    logic [15:0] Score;

    int n_checks = 0;
    int n_pass   = 0;

    quiz_round_controller #(.SCORE_MAX(9)) dut (
        .CLK(CLK), .RSTn(RSTn), .Host_Start(Host_Start), .Host_Abort(Host_Abort),
        .Player_Key(Player_Key), .Judge_Correct(Judge_Correct), .Judge_Wrong(Judge_Wrong),
        .TimerH(TimerH), .TimerL(TimerL), .Timer_Start(Timer_Start), .Timer_RSTn(Timer_RSTn),
        .Winner(Winner), .Winner_Valid(Winner_Valid), .Player_LED(Player_LED),
        .Foul(Foul), .Score(Score)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK); #1;
    endtask

    // Open a round, press player p's key, return just after the grant edge
    task automatic grant(input int p);
        Player_Key = 4'b0; Host_Start = 1'b1; step(); Host_Start = 1'b0;
        Player_Key = 4'(1 << p); step(); step(); Player_Key = 4'b0;
    endtask

    task automatic verdict(input logic jc, input logic jw);
        Judge_Correct = jc; Judge_Wrong = jw; step();
        Judge_Correct = 1'b0; Judge_Wrong = 1'b0; step();
    endtask

    task automatic test_reset();
        #12 RSTn = 1'b1; step();
        n_checks++; if (Winner_Valid !== 1'b0) $display("FAIL rst_valid got=%b want=0", Winner_Valid); else n_pass++;
        n_checks++; if (Timer_RSTn !== 1'b1 || Timer_Start !== 1'b0) $display("FAIL rst_timer got=%b%b want=10", Timer_RSTn, Timer_Start); else n_pass++;
        n_checks++; if ({Winner, Player_LED, Foul} !== 10'd0) $display("FAIL rst_grant got=%h want=0", {Winner, Player_LED, Foul}); else n_pass++;
        n_checks++; if (Score !== 16'h0000) $display("FAIL rst_score got=%h want=0000", Score); else n_pass++;
    endtask

    task automatic test_grant();
        Host_Start = 1'b1; step(); Host_Start = 1'b0;
        Player_Key = 4'b0110; step();
        n_checks++; if (Winner_Valid !== 1'b0) $display("FAIL grant_early got=%b want=0", Winner_Valid); else n_pass++;
        step();
        n_checks++; if ({Winner_Valid, Winner, Player_LED} !== {1'b1, 2'd1, 4'b0010}) $display("FAIL grant_winner got=%b want=1010010", {Winner_Valid, Winner, Player_LED}); else n_pass++;
        n_checks++; if ({Timer_RSTn, Timer_Start} !== 2'b00) $display("FAIL grant_reload got=%b want=00", {Timer_RSTn, Timer_Start}); else n_pass++;
        Player_Key = 4'b0; step();
        n_checks++; if ({Timer_RSTn, Timer_Start} !== 2'b11) $display("FAIL grant_run got=%b want=11", {Timer_RSTn, Timer_Start}); else n_pass++;
        verdict(1'b1, 1'b0);
        n_checks++; if ({Winner_Valid, Timer_Start} !== 2'b00) $display("FAIL grant_exit got=%b want=00", {Winner_Valid, Timer_Start}); else n_pass++;
        n_checks++; if (Score !== 16'h0010) $display("FAIL grant_score got=%h want=0010", Score); else n_pass++;
    endtask

    task automatic test_foul();
        Player_Key = 4'b0100; step(); step();
        n_checks++; if (Foul !== 4'b0100) $display("FAIL foul_set got=%b want=0100", Foul); else n_pass++;
        Player_Key = 4'b0; step();
        Host_Start = 1'b1; step(); Host_Start = 1'b0;
        Player_Key = 4'b0100; step(); step();
        n_checks++; if (Winner_Valid !== 1'b0) $display("FAIL foul_ignored got=%b want=0", Winner_Valid); else n_pass++;
        Player_Key = 4'b1100; step(); step();
        n_checks++; if ({Winner_Valid, Winner} !== 3'b111) $display("FAIL foul_winner got=%b want=111", {Winner_Valid, Winner}); else n_pass++;
        n_checks++; if (Foul !== 4'b0100) $display("FAIL foul_hold got=%b want=0100", Foul); else n_pass++;
        Player_Key = 4'b0;
        verdict(1'b0, 1'b1);
        n_checks++; if (Foul !== 4'b0000) $display("FAIL foul_clear got=%b want=0000", Foul); else n_pass++;
        n_checks++; if (Score !== 16'h0010) $display("FAIL foul_score0 got=%h want=0010", Score); else n_pass++;
    endtask

    task automatic test_saturate();
        grant(0); verdict(1'b1, 1'b0);
        n_checks++; if (Score !== 16'h0011) $display("FAIL sat_first got=%h want=0011", Score); else n_pass++;
        for (int r = 1; r < 10; r++) begin
            grant(0); verdict(1'b1, 1'b0);
        end
        n_checks++; if (Score !== 16'h0019) $display("FAIL sat_max got=%h want=0019", Score); else n_pass++;
        grant(2); verdict(1'b0, 1'b1);
        n_checks++; if (Score !== 16'h0019) $display("FAIL sat_zero got=%h want=0019", Score); else n_pass++;
    endtask

    task automatic test_timeout();
        grant(1); step();
        TimerH = 4'd0; TimerL = 4'd0; step();
        TimerH = 4'd3; step(); step();
        n_checks++; if (Winner_Valid !== 1'b1) $display("FAIL to_early got=%b want=1", Winner_Valid); else n_pass++;
        n_checks++; if (Score !== 16'h0019) $display("FAIL to_early_score got=%h want=0019", Score); else n_pass++;
        TimerH = 4'd0; step(); TimerH = 4'd3;
        n_checks++; if (Winner_Valid !== 1'b1) $display("FAIL to_pending got=%b want=1", Winner_Valid); else n_pass++;
        step();
        n_checks++; if ({Winner_Valid, Timer_Start} !== 2'b00) $display("FAIL to_exit got=%b want=00", {Winner_Valid, Timer_Start}); else n_pass++;
        n_checks++; if (Score !== 16'h0009) $display("FAIL to_score got=%h want=0009", Score); else n_pass++;
        grant(1); step(); step(); step();
        TimerH = 4'd0; TimerL = 4'd0;
        verdict(1'b1, 1'b0);
        TimerH = 4'd3;
        n_checks++; if (Score !== 16'h0019) $display("FAIL to_vs_judge got=%h want=0019", Score); else n_pass++;
    endtask

    task automatic test_abort();
        grant(2); step();
        Host_Abort = 1'b1; Judge_Correct = 1'b1; step();
        Host_Abort = 1'b0; Judge_Correct = 1'b0; step();
        n_checks++; if ({Winner_Valid, Timer_Start, Foul} !== 6'd0) $display("FAIL abort_idle got=%b want=000000", {Winner_Valid, Timer_Start, Foul}); else n_pass++;
        step();
        n_checks++; if (Score !== 16'h0019) $display("FAIL abort_score got=%h want=0019", Score); else n_pass++;
        grant(2);
        verdict(1'b1, 1'b1); step();
        n_checks++; if ({Winner_Valid, Winner} !== 3'b110) $display("FAIL both_hold got=%b want=110", {Winner_Valid, Winner}); else n_pass++;
        n_checks++; if (Score !== 16'h0019) $display("FAIL both_score got=%h want=0019", Score); else n_pass++;
        Host_Abort = 1'b1; step(); Host_Abort = 1'b0; step();
        n_checks++; if (Winner_Valid !== 1'b0) $display("FAIL abort2 got=%b want=0", Winner_Valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        grant(1); step();
        #3 RSTn = 1'b0; #1;
        n_checks++; if ({Winner_Valid, Winner, Player_LED, Foul, Timer_Start} !== 12'd0) $display("FAIL rstmid_grant got=%b want=0", {Winner_Valid, Winner, Player_LED, Foul, Timer_Start}); else n_pass++;
        n_checks++; if (Score !== 16'h0000 || Timer_RSTn !== 1'b1) $display("FAIL rstmid_score got=%h/%b want=0000/1", Score, Timer_RSTn); else n_pass++;
        #2 RSTn = 1'b1; step();
    endtask

    initial begin
        #100000 $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_grant();
        test_foul();
        test_saturate();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
